// File: rtl/output_port_serializer_if.sv
// Output-port serializer bus: nibble writes, clear-to-send in, serial line and status out.
// The master drives nibbles and flow control; the slave is the serializer itself.
interface output_port_serializer_if #(
    parameter int DEPTH = 4
);
    logic [3:0]               nib_in;
    logic                     nib_we;
    logic                     cts;
    logic                     clr_overflow;
    logic                     tx;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;

    modport master (
        output nib_in, nib_we, cts, clr_overflow,
        input  tx, busy, fifo_count, overflow
    );

    modport slave (
        input  nib_in, nib_we, cts, clr_overflow,
        output tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/output_port_serializer.sv
// Queues o_reg nibbles in a FIFO and sends each as a start/4-data/even-parity/stop frame, DIV cycles per bit.
// Latency: tx falls one edge after the capturing write; a full FIFO drops writes (sticky overflow) unless popped that edge.
module output_port_serializer #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output_port_serializer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [1:0]     bit_q, bit_d;
    logic [3:0]     sh_q, sh_d;
    logic           tx_q, tx_d;
    logic [3:0]     mem_q [DEPTH];
    logic [3:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           ovf_q, ovf_d;

    logic           pop, push, drop, cyc_end;

    assign cyc_end = (cyc_q == CW'(DIV - 1));
    // Pops happen only from IDLE, which guarantees the idle-high cycle between frames.
    assign pop  = (state_q == IDLE) && (cnt_q != '0) && bus.cts;
    assign push = bus.nib_we && ((cnt_q != (AW+1)'(DEPTH)) || pop);
    assign drop = bus.nib_we && !push;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.nib_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        // A drop on the same edge as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (state_q == IDLE) begin
            if (pop) begin
                state_d = START;
                cyc_d   = '0;
                bit_d   = '0;
                sh_d    = mem_q[rd_ptr_q];
            end
        end else if (!cyc_end) begin
            cyc_d = cyc_q + CW'(1);
        end else begin
            cyc_d = '0;
            case (state_q)
                START:  state_d = DATA;
                DATA: begin
                    if (bit_q == 2'd3) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + 2'd1;
                    end
                end
                PARITY: state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    // tx is registered, so it is decoded from the state being entered.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[bit_d];
            PARITY:  tx_d = ^sh_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_count = cnt_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_output_port_serializer.sv
// Directed bench for output_port_serializer (DIV=4, DEPTH=4); inputs driven and outputs sampled on the falling edge.
module tb_output_port_serializer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   w;

    output_port_serializer_if #(.DEPTH(4)) bus ();

    output_port_serializer #(.DIV(4), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered on the first start-bit sample; leaves on the last stop-bit sample.
    task automatic frame_check(input logic [3:0] nib, input int drop_at);
        logic [6:0] bits;
        bits = {1'b1, ^nib, nib[3], nib[2], nib[1], nib[0], 1'b0};
        for (int i = 0; i < 28; i++) begin
            if (i == drop_at) bus.cts = 1'b0;
            chk($sformatf("frame_%h_tx_%0d", nib, i), {31'd0, bus.tx}, {31'd0, bits[i/4]});
            chk($sformatf("frame_%h_busy_%0d", nib, i), {31'd0, bus.busy}, 1);
            if (i < 27) @(negedge clk);
        end
    endtask

    task automatic wait_start(input int budget, output int waited);
        waited = 0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (bus.tx === 1'b0) break;
        end
    endtask

    initial begin
        logic [3:0] seq [5];
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.nib_in = 4'h0;
        bus.nib_we = 1'b0;
        bus.cts = 1'b0;
        bus.clr_overflow = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tx", {31'd0, bus.tx}, 1);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_count", {29'd0, bus.fifo_count}, 0);
        chk("rst_ovf", {31'd0, bus.overflow}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single nibble 0xA
        bus.cts = 1'b1;
        bus.nib_in = 4'hA;
        bus.nib_we = 1'b1;
        @(negedge clk);
        bus.nib_we = 1'b0;
        chk("single_count_after_write", {29'd0, bus.fifo_count}, 1);
        chk("single_tx_before_start", {31'd0, bus.tx}, 1);
        chk("single_busy_before_start", {31'd0, bus.busy}, 0);
        @(negedge clk);
        chk("single_count_after_pop", {29'd0, bus.fifo_count}, 0);
        frame_check(4'hA, -1);
        @(negedge clk);
        chk("single_busy_end", {31'd0, bus.busy}, 0);
        chk("single_tx_end", {31'd0, bus.tx}, 1);

        // Overflow with cts low, then drain in order
        bus.cts = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.nib_in = 4'(i);
            bus.nib_we = 1'b1;
            @(negedge clk);
            chk($sformatf("ovf_count_w%0d", i), {29'd0, bus.fifo_count}, (i < 4) ? i : 4);
            chk($sformatf("ovf_flag_w%0d", i), {31'd0, bus.overflow}, (i >= 5) ? 1 : 0);
        end
        bus.nib_we = 1'b0;
        bus.cts = 1'b1;
        wait_start(5, w);
        chk("drain_first_latency", w, 1);
        chk("drain_count_after_pop", {29'd0, bus.fifo_count}, 3);
        frame_check(4'h1, -1);
        for (int n = 2; n <= 4; n++) begin
            wait_start(5, w);
            chk($sformatf("drain_gap_%0d", n), w, 2);
            frame_check(4'(n), -1);
        end
        @(negedge clk);
        chk("drain_count_end", {29'd0, bus.fifo_count}, 0);
        chk("drain_ovf_sticky", {31'd0, bus.overflow}, 1);

        // Clear, refill, clear race, then write on the pop edge of a full FIFO
        bus.cts = 1'b0;
        bus.clr_overflow = 1'b1;
        @(negedge clk);
        bus.clr_overflow = 1'b0;
        chk("clr_alone", {31'd0, bus.overflow}, 0);
        seq = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h7};
        for (int i = 0; i < 4; i++) begin
            bus.nib_in = seq[i];
            bus.nib_we = 1'b1;
            @(negedge clk);
        end
        bus.nib_in = 4'hC;
        bus.clr_overflow = 1'b1;
        @(negedge clk);
        chk("race_ovf_set_wins", {31'd0, bus.overflow}, 1);
        chk("race_count", {29'd0, bus.fifo_count}, 4);
        bus.nib_we = 1'b0;
        @(negedge clk);
        bus.clr_overflow = 1'b0;
        chk("race_clr_later", {31'd0, bus.overflow}, 0);
        bus.cts = 1'b1;
        bus.nib_in = 4'h7;
        bus.nib_we = 1'b1;
        @(negedge clk);
        bus.nib_we = 1'b0;
        chk("fullpop_count", {29'd0, bus.fifo_count}, 4);
        chk("fullpop_ovf", {31'd0, bus.overflow}, 0);
        frame_check(seq[0], -1);
        for (int i = 1; i < 5; i++) begin
            wait_start(5, w);
            chk($sformatf("fullpop_gap_%0d", i), w, 2);
            frame_check(seq[i], -1);
        end
        @(negedge clk);
        chk("fullpop_count_end", {29'd0, bus.fifo_count}, 0);
        chk("fullpop_busy_end", {31'd0, bus.busy}, 0);

        // cts drop during DATA of frame 1
        bus.cts = 1'b0;
        bus.nib_in = 4'h5;
        bus.nib_we = 1'b1;
        @(negedge clk);
        bus.nib_in = 4'h6;
        @(negedge clk);
        bus.nib_we = 1'b0;
        chk("cts_count_queued", {29'd0, bus.fifo_count}, 2);
        bus.cts = 1'b1;
        @(negedge clk);
        chk("cts_count_after_pop", {29'd0, bus.fifo_count}, 1);
        frame_check(4'h5, 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("cts_hold_tx_%0d", i), {31'd0, bus.tx}, 1);
        end
        chk("cts_hold_count", {29'd0, bus.fifo_count}, 1);
        chk("cts_hold_busy", {31'd0, bus.busy}, 0);
        bus.cts = 1'b1;
        @(negedge clk);
        frame_check(4'h6, -1);
        @(negedge clk);

        // Async reset mid-DATA with 3 queued and overflow set
        bus.cts = 1'b0;
        seq = '{4'hE, 4'hD, 4'hF, 4'h1, 4'h2};
        for (int i = 0; i < 5; i++) begin
            bus.nib_in = seq[i];
            bus.nib_we = 1'b1;
            @(negedge clk);
        end
        bus.nib_we = 1'b0;
        chk("arst_pre_ovf", {31'd0, bus.overflow}, 1);
        bus.cts = 1'b1;
        @(negedge clk);
        bus.cts = 1'b0;
        chk("arst_pre_start", {31'd0, bus.tx}, 0);
        chk("arst_pre_count", {29'd0, bus.fifo_count}, 3);
        repeat (5) @(negedge clk);
        chk("arst_pre_data_tx", {31'd0, bus.tx}, 0);
        chk("arst_pre_data_busy", {31'd0, bus.busy}, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_tx", {31'd0, bus.tx}, 1);
        chk("arst_busy", {31'd0, bus.busy}, 0);
        chk("arst_count", {29'd0, bus.fifo_count}, 0);
        chk("arst_ovf", {31'd0, bus.overflow}, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.cts = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("arst_after_tx_%0d", i), {31'd0, bus.tx}, 1);
        end
        chk("arst_after_busy", {31'd0, bus.busy}, 0);
        chk("arst_after_count", {29'd0, bus.fifo_count}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/output_port_serializer.md
Name: output_port_serializer

Overview:
Downstream consumer of the microprocessor's output-port path. Each time the instruction decoder strobes a load of o_reg, the block captures the nibble on the data bus into a small FIFO. It then shifts each nibble out on a single serial line as a framed word (start, 4 data bits, even parity, stop), paced by a clock divider and gated by a clear-to-send input. This lets a program's output stream leave the chip on one pin without stalling the processor.

Parameters:
DIV, 4, clock cycles per serial bit; must be at least 1.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
nib_in  input  4  nibble to queue; connected to the data bus.
nib_we  input  1  o_reg load strobe from the instruction decoder; nib_in is captured on the same edge that loads o_reg.
cts  input  1  clear to send; high permits a new frame to start.
clr_overflow  input  1  synchronous clear of overflow.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress (state is not IDLE).
fifo_count  output  clog2(DEPTH)+1  number of queued nibbles, from 0 to DEPTH.
overflow  output  1  sticky flag; set when a write is dropped.

Behaviour:
- Reset (async, reset=0):
  - tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE.
  - FIFO pointers and bit/cycle counters are cleared.
  - Reset asserted mid-frame forces tx high immediately and discards the FIFO contents.
- FIFO:
  - Circular buffer with separate read and write pointers, each wrapping modulo DEPTH.
  - A write is accepted when nib_we=1 and either fifo_count<DEPTH or a pop occurs on the same edge.
  - An accepted write is visible in fifo_count after that edge.
  - A write that is not accepted is dropped and sets overflow on that edge.
  - A simultaneous push and pop leaves fifo_count unchanged.
- Overflow flag:
  - overflow clears on clr_overflow=1.
  - If a drop and clr_overflow occur on the same edge, the set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo_count>0 and cts=1 at the edge, pop the head into the shift register, go to START, and drive tx=0. Otherwise tx=1.
  - START: tx=0 for DIV cycles, then go to DATA.
  - DATA: drive 4 bits LSB first, each for DIV cycles. A 2-bit bit index counts 0 to 3; after bit 3 go to PARITY.
  - PARITY: tx = XOR of the 4 data bits (even parity over data plus parity) for DIV cycles, then go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Timing:
  - tx is registered. The cycle counter runs from 0 to DIV-1 and advances the state on the edge at DIV-1.
  - A frame is exactly 7*DIV cycles.
  - At least 1 idle-high cycle (the IDLE state) separates back-to-back frames, so the frame period is 7*DIV+1 cycles.
- Latency: nib_we at edge k with an empty FIFO, IDLE state and cts=1 means tx falls after edge k+1.
- cts is sampled only in IDLE. Deasserting cts mid-frame never aborts the frame; the next frame waits for cts=1.
- A pop removes the entry from the FIFO; the shifted data is held in its own register, so writes arriving during a frame never corrupt it.
- Nibbles are transmitted in write order.

Test Plan:
- Single nibble, DIV=4, cts=1: nib_in=4'hA with one nib_we pulse.
  - Required: tx falls one cycle later.
  - Bit sequence 0,0,1,0,1,0,1, each held 4 cycles.
  - busy high for 28 cycles; fifo_count returns to 0.
- Overflow, DEPTH=4, cts=0: write 1,2,3,4,5,6 on consecutive cycles.
  - Required: fifo_count=4 and overflow=1 after the 5th write; 5 and 6 are dropped.
  - Raise cts: frames carry 1,2,3,4 in order, with a 1-cycle idle gap between frames.
- Full plus pop: with FIFO full and IDLE, raise cts and pulse nib_we with 4'h7 on the pop edge.
  - Required: fifo_count stays 4, overflow stays 0, and 7 is the last frame sent.
- cts drop: lower cts during the DATA state of frame 1 with 2 nibbles queued.
  - Required: frame 1 completes unchanged; tx stays high and fifo_count=1 until cts=1, then frame 2 starts 1 cycle later.
- Async reset: assert reset=0 mid-DATA with 3 queued.
  - Required: tx=1, busy=0, fifo_count=0, overflow=0 without waiting for a clock edge; after release, no frame starts.
- Overflow clear race: drive clr_overflow=1 on the same edge as a dropped write.
  - Required: overflow=1. clr_overflow alone on a later edge clears it to 0.
